conv_fold_core: RTL and testbench



---
 rtl/conv_fold_core.sv | 175 +++++++++++++++++
 tb/tb_conv_fold_core.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_fold_core.sv
// Time-folded multi-channel FIR core: one multiplier per channel iterated over TAPS
// coefficients per sample, with rounding shift, output saturation and sticky error flags.
module conv_fold_core #(
   parameter int CH    = 2,
   parameter int DW    = 16,
   parameter int CW    = 16,
   parameter int TAPS  = 200,
   parameter int OW    = 16,
   parameter int SHIFT = 15,
   parameter int AW    = $clog2(TAPS)
) (
   input  logic             clkf,
   input  logic             rst,
   input  logic             koef_en,
   input  logic [CW-1:0]    KOEF_IN,
   input  logic             koef_ptr_clr,
   input  logic             data_in_en,
   input  logic [CH*DW-1:0] DATA_IN,
   input  logic             clear_flags,
   output logic             data_out_en,
   output logic [CH*OW-1:0] DATA_OUT,
   output logic [CH-1:0]    OUT_SAT,
   output logic             busy,
   output logic             overrun,
   output logic             koef_err
);
   localparam int unsigned PW  = DW + CW;
   localparam int unsigned ACW = PW + AW;
   localparam int unsigned RW  = ACW + 1;
   localparam int unsigned FW  = AW + 1;
   localparam int unsigned RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
   localparam logic [FW-1:0] FULL = FW'(TAPS);
   localparam logic signed [RW-1:0] RND  = (SHIFT > 0) ? (RW'(1) << RSH) : '0;
   localparam logic signed [RW-1:0] SMAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [RW-1:0] SMIN = {{(RW-OW+1){1'b1}}, {(OW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_FLUSH, S_ROUND} state_t;

   state_t               state;
   logic [AW-1:0]        kptr, wp, rp, k;
   logic [FW-1:0]        fill;
   logic [1:0]           fl_cnt;
   logic                 v1, first1, v2, first2;
   logic signed [CW-1:0] rd_c;
   logic signed [DW-1:0] rd_x [CH];
   logic signed [PW-1:0] prod [CH];
   logic signed [ACW-1:0] acc [CH];

   logic signed [CW-1:0] coef [TAPS];
   logic signed [DW-1:0] hist [CH][TAPS];

   logic                 idle_c, coef_we_c, sample_we_c;
   logic [AW-1:0]        ksel_c;
   logic signed [RW-1:0] sh_c [CH];
   logic [OW-1:0]        y_c [CH];
   logic [CH-1:0]        sat_c;

   // Write qualifiers: coefficient and sample writes only land while idle
   always_comb begin
      idle_c      = (state == S_IDLE);
      coef_we_c   = koef_en && idle_c && !rst;
      sample_we_c = data_in_en && idle_c && !rst;
      ksel_c      = koef_ptr_clr ? '0 : kptr;
   end

   // Coefficient and history storage; contents survive reset, history is masked by fill
   always_ff @(posedge clkf) begin
      if (coef_we_c) coef[ksel_c] <= KOEF_IN;
      if (sample_we_c)
         for (int c = 0; c < CH; c++) hist[c][wp] <= DATA_IN[c*DW +: DW];
   end

   // Round half up, then clip to the output range
   always_comb begin
      sat_c = '0;
      for (int c = 0; c < CH; c++) begin
         sh_c[c] = (RW'(acc[c]) + RND) >>> SHIFT;
         y_c[c]  = OW'(sh_c[c]);
         if (sh_c[c] > SMAX) begin
            y_c[c]   = OW'(SMAX);
            sat_c[c] = 1'b1;
         end else if (sh_c[c] < SMIN) begin
            y_c[c]   = OW'(SMIN);
            sat_c[c] = 1'b1;
         end
      end
   end

   // MAC pipeline: read -> product -> accumulate; taps beyond fill read as zero
   always_ff @(posedge clkf or posedge rst) begin
      if (rst) begin
         v1     <= 1'b0;
         first1 <= 1'b0;
         v2     <= 1'b0;
         first2 <= 1'b0;
         rd_c   <= '0;
         for (int c = 0; c < CH; c++) begin
            rd_x[c] <= '0;
            prod[c] <= '0;
            acc[c]  <= '0;
         end
      end else begin
         v1     <= (state == S_MAC);
         first1 <= (state == S_MAC) && (k == '0);
         v2     <= v1;
         first2 <= first1;
         rd_c   <= coef[k];
         for (int c = 0; c < CH; c++) begin
            rd_x[c] <= ({1'b0, k} < fill) ? hist[c][rp] : '0;
            prod[c] <= PW'(rd_x[c]) * PW'(rd_c);
            if (v2) acc[c] <= first2 ? ACW'(prod[c]) : acc[c] + ACW'(prod[c]);
         end
      end
   end

   // Control FSM with registered outputs and sticky flags
   always_ff @(posedge clkf or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         kptr        <= '0;
         wp          <= '0;
         rp          <= '0;
         k           <= '0;
         fill        <= '0;
         fl_cnt      <= '0;
         data_out_en <= 1'b0;
         DATA_OUT    <= '0;
         OUT_SAT     <= '0;
         busy        <= 1'b0;
         overrun     <= 1'b0;
         koef_err    <= 1'b0;
      end else begin
         data_out_en <= 1'b0;
         overrun     <= (data_in_en && !idle_c) || (overrun && !clear_flags);
         koef_err    <= (koef_en && !idle_c) || (koef_err && !clear_flags);
         if (coef_we_c) kptr <= (ksel_c == LAST) ? '0 : ksel_c + AW'(1);
         else if (koef_ptr_clr) kptr <= '0;

         case (state)
            S_IDLE: begin
               if (data_in_en) begin
                  wp    <= (wp == LAST) ? '0 : wp + AW'(1);
                  rp    <= wp;
                  fill  <= (fill == FULL) ? fill : fill + FW'(1);
                  k     <= '0;
                  busy  <= 1'b1;
                  state <= S_MAC;
               end
            end
            S_MAC: begin
               rp <= (rp == '0) ? LAST : rp - AW'(1);
               if (k == LAST) begin
                  fl_cnt <= '0;
                  state  <= S_FLUSH;
               end else begin
                  k <= k + AW'(1);
               end
            end
            S_FLUSH: begin
               fl_cnt <= fl_cnt + 2'd1;
               if (fl_cnt == 2'd1) state <= S_ROUND;
            end
            S_ROUND: begin
               for (int c = 0; c < CH; c++) DATA_OUT[c*OW +: OW] <= y_c[c];
               OUT_SAT     <= sat_c;
               data_out_en <= 1'b1;
               busy        <= 1'b0;
               state       <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_conv_fold_core.sv
// Bench for conv_fold_core: two instances (SHIFT=0 and SHIFT=15, TAPS=8) on shared stimulus,
// compared against a queue-based convolution model.
module tb_conv_fold_core;
   localparam int T = 8;

   logic        clkf = 1'b0;
   logic        rst, koef_en, koef_ptr_clr, data_in_en, clear_flags;
   logic [15:0] koef_in;
   logic [31:0] data_in;
   logic        oen_a, oen_b, busy_a, busy_b, ovr_a, ovr_b, kerr_a, kerr_b;
   logic [31:0] dout_a, dout_b;
   logic [1:0]  sat_a, sat_b;

   always #5 clkf = ~clkf;

   conv_fold_core #(.CH(2), .DW(16), .CW(16), .TAPS(T), .OW(16), .SHIFT(0)) dut_a (
      .clkf(clkf), .rst(rst), .koef_en(koef_en), .KOEF_IN(koef_in), .koef_ptr_clr(koef_ptr_clr),
      .data_in_en(data_in_en), .DATA_IN(data_in), .clear_flags(clear_flags),
      .data_out_en(oen_a), .DATA_OUT(dout_a), .OUT_SAT(sat_a), .busy(busy_a),
      .overrun(ovr_a), .koef_err(kerr_a));

   conv_fold_core #(.CH(2), .DW(16), .CW(16), .TAPS(T), .OW(16), .SHIFT(15)) dut_b (
      .clkf(clkf), .rst(rst), .koef_en(koef_en), .KOEF_IN(koef_in), .koef_ptr_clr(koef_ptr_clr),
      .data_in_en(data_in_en), .DATA_IN(data_in), .clear_flags(clear_flags),
      .data_out_en(oen_b), .DATA_OUT(dout_b), .OUT_SAT(sat_b), .busy(busy_b),
      .overrun(ovr_b), .koef_err(kerr_b));

   int checks = 0;
   int errors = 0;
   int coef_m [T];
   int h0 [$];
   int h1 [$];
   logic [33:0] obs_a, obs_b, ea, eb;
   int  lat;
   logic both_en, busy_o;

   task automatic tick();
      @(posedge clkf);
      #1;
   endtask

   // Round half up by 2^sh (floor of shifted value) then clip to 16-bit signed: {sat, value}
   function automatic logic [16:0] rs(input longint y, input int sh);
      longint v = y;
      if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
      if (v > 32767) return {1'b1, 16'h7fff};
      if (v < -32768) return {1'b1, 16'h8000};
      return {1'b0, v[15:0]};
   endfunction

   // Direct convolution of the newest sample history with the coefficient set: {sat1,sat0,y1,y0}
   function automatic logic [33:0] model_out(input int sh);
      longint y0 = 0;
      longint y1 = 0;
      logic [16:0] r0, r1;
      for (int i = 0; i < h0.size(); i++) begin
         y0 += longint'(coef_m[i]) * longint'(h0[h0.size() - 1 - i]);
         y1 += longint'(coef_m[i]) * longint'(h1[h1.size() - 1 - i]);
      end
      r0 = rs(y0, sh);
      r1 = rs(y1, sh);
      return {r1[16], r0[16], r1[15:0], r0[15:0]};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      h0.delete();
      h1.delete();
      tick();
   endtask

   task automatic load_coefs();
      for (int i = 0; i < T; i++) begin
         koef_en      = 1'b1;
         koef_ptr_clr = (i == 0);
         koef_in      = 16'(coef_m[i]);
         tick();
      end
      koef_en      = 1'b0;
      koef_ptr_clr = 1'b0;
   endtask

   // Strobe one accepted sample; the model history takes it
   task automatic start(input logic [15:0] x0, input logic [15:0] x1);
      data_in    = {x1, x0};
      data_in_en = 1'b1;
      h0.push_back(int'($signed(x0)));
      h1.push_back(int'($signed(x1)));
      if (h0.size() > T) void'(h0.pop_front());
      if (h1.size() > T) void'(h1.pop_front());
      tick();
      data_in_en = 1'b0;
   endtask

   // lat = rising edges from the one sampling data_in_en to the one sampling data_out_en high
   task automatic wait_out(input int n0);
      int n = n0;
      bit found = 1'b0;
      while (!found && n < 60) begin
         tick();
         n++;
         if (oen_a) found = 1'b1;
      end
      lat     = found ? n + 1 : -1;
      obs_a   = {sat_a, dout_a};
      obs_b   = {sat_b, dout_b};
      both_en = oen_a & oen_b;
      busy_o  = busy_a | busy_b;
      ea      = model_out(0);
      eb      = model_out(15);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      checks++;
      if ({oen_a, dout_a, sat_a, busy_a, ovr_a, kerr_a} !== 38'd0) begin
         errors++;
         $display("FAIL reset_a: got %h want 0", {oen_a, dout_a, sat_a, busy_a, ovr_a, kerr_a});
      end
      checks++;
      if ({oen_b, dout_b, sat_b, busy_b, ovr_b, kerr_b} !== 38'd0) begin
         errors++;
         $display("FAIL reset_b: got %h want 0", {oen_b, dout_b, sat_b, busy_b, ovr_b, kerr_b});
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_impulse();
      for (int i = 0; i < T; i++) coef_m[i] = i + 1;
      do_reset();
      load_coefs();
      for (int i = 0; i < T; i++) begin
         start((i == 0) ? 16'd1000 : 16'd0, (i == 0) ? 16'hfffd : 16'd0);
         wait_out(0);
         checks++;
         if (lat !== T + 4 || both_en !== 1'b1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL impulse_timing[%0d]: got lat=%0d en=%b busy=%b want lat=%0d en=1 busy=0",
                     i, lat, both_en, busy_o, T + 4);
         end
         checks++;
         if (obs_a[15:0] !== 16'(1000 * (i + 1))) begin
            errors++;
            $display("FAIL impulse_val[%0d]: got %0d want %0d", i, obs_a[15:0], 1000 * (i + 1));
         end
         checks++;
         if (obs_a !== ea || obs_b !== eb) begin
            errors++;
            $display("FAIL impulse_model[%0d]: got %h/%h want %h/%h", i, obs_a, obs_b, ea, eb);
         end
      end
   endtask

   task automatic test_zero_init();
      for (int i = 0; i < T; i++) coef_m[i] = 1;
      do_reset();
      load_coefs();
      for (int i = 0; i < T + 1; i++) begin
         start(16'd5, 16'($urandom));
         wait_out(0);
         checks++;
         if (obs_a !== ea || obs_b !== eb) begin
            errors++;
            $display("FAIL zero_init_model[%0d]: got %h/%h want %h/%h", i, obs_a, obs_b, ea, eb);
         end
         if (i == 0 || i == T) begin
            checks++;
            if (obs_a[15:0] !== ((i == 0) ? 16'd5 : 16'd40)) begin
               errors++;
               $display("FAIL zero_init_val[%0d]: got %0d want %0d", i, obs_a[15:0], (i == 0) ? 5 : 40);
            end
         end
      end
   endtask

   task automatic test_round_sat();
      for (int i = 0; i < T; i++) coef_m[i] = (i == 0) ? 16384 : 0;
      do_reset();
      load_coefs();
      start(16'd3, 16'($urandom));
      wait_out(0);
      checks++;
      if (obs_b[15:0] !== 16'd2 || obs_b[32] !== 1'b0 || obs_b !== eb || obs_a !== ea) begin
         errors++;
         $display("FAIL round_half_up: got %h/%h want y0=2 model %h/%h", obs_a, obs_b, ea, eb);
      end
      for (int i = 0; i < T; i++) coef_m[i] = 32767;
      for (int p = 0; p < 2; p++) begin
         do_reset();
         if (p == 0) load_coefs();
         for (int i = 0; i < T; i++) begin
            start((p == 0) ? 16'h7fff : 16'h8000, 16'($urandom));
            wait_out(0);
            checks++;
            if (obs_a !== ea || obs_b !== eb) begin
               errors++;
               $display("FAIL sat_model[%0d/%0d]: got %h/%h want %h/%h", p, i, obs_a, obs_b, ea, eb);
            end
         end
         checks++;
         if (obs_b[15:0] !== ((p == 0) ? 16'h7fff : 16'h8000) || obs_b[32] !== 1'b1) begin
            errors++;
            $display("FAIL sat_clip[%0d]: got y=%h sat=%b want %h sat=1", p, obs_b[15:0], obs_b[32],
                     (p == 0) ? 16'h7fff : 16'h8000);
         end
      end
   endtask

   task automatic test_overrun();
      do_reset();
      start(16'($urandom), 16'($urandom));
      repeat (4) tick();
      data_in    = 32'h1234_5678;
      data_in_en = 1'b1;
      tick();
      data_in_en = 1'b0;
      wait_out(5);
      checks++;
      if (lat !== T + 4 || obs_a !== ea || obs_b !== eb) begin
         errors++;
         $display("FAIL overrun_result: got lat=%0d %h/%h want lat=%0d %h/%h", lat, obs_a, obs_b, T + 4, ea, eb);
      end
      checks++;
      if ({ovr_a, ovr_b} !== 2'b11) begin
         errors++;
         $display("FAIL overrun_set: got %b want 11", {ovr_a, ovr_b});
      end
      begin
         int extra = 0;
         for (int i = 0; i < 20; i++) begin
            tick();
            if (oen_a || oen_b) extra++;
         end
         checks++;
         if (extra !== 0) begin
            errors++;
            $display("FAIL overrun_single: got %0d extra results want 0", extra);
         end
      end
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      checks++;
      if ({ovr_a, ovr_b} !== 2'b00) begin
         errors++;
         $display("FAIL overrun_clear: got %b want 00", {ovr_a, ovr_b});
      end
      start(16'($urandom), 16'($urandom));
      tick();
      clear_flags = 1'b1;
      data_in_en  = 1'b1;
      tick();
      clear_flags = 1'b0;
      data_in_en  = 1'b0;
      checks++;
      if ({ovr_a, ovr_b} !== 2'b11) begin
         errors++;
         $display("FAIL overrun_clear_vs_event: got %b want 11", {ovr_a, ovr_b});
      end
      wait_out(2);
      checks++;
      if (obs_a !== ea || obs_b !== eb) begin
         errors++;
         $display("FAIL overrun_history: got %h/%h want %h/%h", obs_a, obs_b, ea, eb);
      end
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
   endtask

   task automatic test_koef_ctrl();
      logic [15:0] v;
      do_reset();
      for (int i = 0; i < T + 1; i++) begin
         v                = 16'($urandom);
         koef_en          = 1'b1;
         koef_ptr_clr     = (i == 0);
         koef_in          = v;
         coef_m[i % T]    = int'($signed(v));
         tick();
      end
      koef_en      = 1'b0;
      koef_ptr_clr = 1'b0;
      for (int i = 0; i < T; i++) begin
         start((i == 0) ? 16'd1 : 16'd0, (i == 0) ? 16'hffff : 16'd0);
         wait_out(0);
         checks++;
         if (obs_a !== ea || obs_b !== eb) begin
            errors++;
            $display("FAIL koef_wrap_model[%0d]: got %h/%h want %h/%h", i, obs_a, obs_b, ea, eb);
         end
      end
      start(16'($urandom), 16'($urandom));
      repeat (3) tick();
      koef_en = 1'b1;
      koef_in = 16'h5555;
      tick();
      koef_en = 1'b0;
      wait_out(4);
      checks++;
      if ({kerr_a, kerr_b} !== 2'b11 || obs_a !== ea || obs_b !== eb) begin
         errors++;
         $display("FAIL koef_busy: got err=%b %h/%h want err=11 %h/%h", {kerr_a, kerr_b}, obs_a, obs_b, ea, eb);
      end
      clear_flags = 1'b1;
      tick();
      clear_flags = 1'b0;
      checks++;
      if ({kerr_a, kerr_b} !== 2'b00) begin
         errors++;
         $display("FAIL koef_err_clear: got %b want 00", {kerr_a, kerr_b});
      end
   endtask

   task automatic test_reset_mid();
      int extra = 0;
      start(16'd7, 16'd9);
      repeat (3) tick();
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({busy_a, busy_b, oen_a, oen_b, dout_a, dout_b} !== 68'd0) begin
         errors++;
         $display("FAIL reset_mid_state: got busy=%b%b en=%b%b out=%h/%h want all 0",
                  busy_a, busy_b, oen_a, oen_b, dout_a, dout_b);
      end
      tick();
      rst = 1'b0;
      h0.delete();
      h1.delete();
      for (int i = 0; i < 20; i++) begin
         tick();
         if (oen_a || oen_b) extra++;
      end
      checks++;
      if (extra !== 0) begin
         errors++;
         $display("FAIL reset_mid_no_out: got %0d results want 0", extra);
      end
      for (int i = 0; i < T; i++) begin
         start((i == 0) ? 16'd1 : 16'd0, (i == 0) ? 16'hffff : 16'd0);
         wait_out(0);
         checks++;
         if (obs_a !== ea || obs_b !== eb || lat !== T + 4) begin
            errors++;
            $display("FAIL reset_mid_impulse[%0d]: got %h/%h lat=%0d want %h/%h lat=%0d",
                     i, obs_a, obs_b, lat, ea, eb, T + 4);
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < T; i++)
            coef_m[i] = (r == 1) ? int'($urandom_range(0, 15)) - 8 : int'($signed(16'($urandom)));
         load_coefs();
         for (int i = 0; i < 10; i++) begin
            if (r == 1) start(16'(int'($urandom_range(0, 255)) - 128), 16'($urandom));
            else start(16'($urandom), 16'($urandom));
            wait_out(0);
            checks++;
            if (obs_a !== ea || obs_b !== eb || lat !== T + 4) begin
               errors++;
               $display("FAIL random[%0d/%0d]: got %h/%h lat=%0d want %h/%h lat=%0d",
                        r, i, obs_a, obs_b, lat, ea, eb, T + 4);
            end
         end
      end
   endtask

   initial begin
      rst          = 1'b0;
      koef_en      = 1'b0;
      koef_ptr_clr = 1'b0;
      data_in_en   = 1'b0;
      clear_flags  = 1'b0;
      koef_in      = '0;
      data_in      = '0;
      #2;
      test_reset();
      test_impulse();
      test_zero_init();
      test_round_sat();
      test_overrun();
      test_koef_ctrl();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
